// File: rtl/line_fill_mem_if.sv
// Cache-to-memory bus: line fill / writeback requests plus fill beats,
// writeback completion and transaction counters.
interface line_fill_mem_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int WORDS  = 4,
   parameter int CNT_W  = 16
);
   localparam int WI = $clog2(WORDS);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_W-1:0]       req_addr;
   logic [WORDS*DATA_W-1:0] req_wdata;
   logic                    rd_valid;
   logic [DATA_W-1:0]       rd_data;
   logic [WI-1:0]           rd_word;
   logic                    rd_last;
   logic                    wr_done;
   logic [CNT_W-1:0]        rd_count;
   logic [CNT_W-1:0]        wr_count;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rd_valid, rd_data, rd_word, rd_last, wr_done, rd_count, wr_count
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rd_valid, rd_data, rd_word, rd_last, wr_done, rd_count, wr_count
   );
endinterface

// File: rtl/line_fill_mem.sv
// Backing memory behind the cache: fixed-latency line fills (critical word
// first, wrapping inside the line) and whole-line writebacks.
module line_fill_mem #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int WORDS   = 4,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 16
) (
   input  logic          clk,
   input  logic          rst,
   line_fill_mem_if.slave bus
);
   localparam int WI    = $clog2(WORDS);
   localparam int OFF   = WI + 2;
   localparam int LW    = ADDR_W - OFF;
   localparam int IW    = ADDR_W - 2;
   localparam int DEPTH = 2 ** IW;
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2, WDONE = 2'd3} state_t;

   state_t                  state_r, state_s;
   logic [LW-1:0]           line_r;
   logic [WI-1:0]           start_r;
   logic                    write_r;
   logic [WORDS*DATA_W-1:0] wdata_r;
   logic [LAT_W-1:0]        cnt_r;
   logic [WI-1:0]           beat_r;
   logic                    ready_r, rd_valid_r, rd_last_r, wr_done_r;
   logic [DATA_W-1:0]       rd_data_r;
   logic [WI-1:0]           rd_word_r;
   logic [CNT_W-1:0]        rd_count_r, wr_count_r;

   logic                    fire_s;
   logic [LW-1:0]           nxt_line_s;
   logic [WI-1:0]           nxt_start_s, nxt_beat_s, nxt_word_s;
   logic [IW-1:0]           rd_idx_s;
   logic                    ready_d_s, rd_valid_d_s, rd_last_d_s, wr_done_d_s;
   logic [DATA_W-1:0]       rd_data_d_s;
   logic [WI-1:0]           rd_word_d_s;
   logic                    unused_s;

   // The array holds data XOR the power-up image, so an all-zero array reads as A000_0000|index.
   logic [DATA_W-1:0]       mem_r [DEPTH];

   function automatic logic [DATA_W-1:0] init_word(input logic [IW-1:0] idx);
      init_word = DATA_W'(32'hA000_0000) | DATA_W'(idx);
   endfunction

   assign fire_s   = bus.req_valid & ready_r;
   assign unused_s = ^bus.req_addr[1:0];

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (fire_s) begin
               if (LATENCY == 1) state_s = bus.req_write ? WDONE : BURST;
               else              state_s = WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == LAT_W'(1)) state_s = write_r ? WDONE : BURST;
            else                    state_s = WAIT;
         end
         BURST: begin
            if (beat_r == WI'(WORDS - 1)) state_s = IDLE;
            else                          state_s = BURST;
         end
         WDONE:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, driven from the upcoming state.
   always_comb begin
      if (state_r == BURST) nxt_beat_s = beat_r + WI'(1);
      else                  nxt_beat_s = '0;
      if (state_r == IDLE) begin
         nxt_line_s  = bus.req_addr[ADDR_W-1:OFF];
         nxt_start_s = bus.req_addr[OFF-1:2];
      end else begin
         nxt_line_s  = line_r;
         nxt_start_s = start_r;
      end
      nxt_word_s  = nxt_start_s + nxt_beat_s;
      rd_idx_s    = {nxt_line_s, nxt_word_s};
      ready_d_s   = (state_s == IDLE);
      wr_done_d_s = (state_s == WDONE);
      if (state_s == BURST) begin
         rd_valid_d_s = 1'b1;
         rd_word_d_s  = nxt_word_s;
         rd_data_d_s  = mem_r[rd_idx_s] ^ init_word(rd_idx_s);
         rd_last_d_s  = (nxt_beat_s == WI'(WORDS - 1));
      end else begin
         rd_valid_d_s = 1'b0;
         rd_word_d_s  = '0;
         rd_data_d_s  = '0;
         rd_last_d_s  = 1'b0;
      end
   end

   // State register, request capture, latency/beat counters, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         line_r     <= '0;
         start_r    <= '0;
         write_r    <= 1'b0;
         wdata_r    <= '0;
         cnt_r      <= '0;
         beat_r     <= '0;
         ready_r    <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
         rd_word_r  <= '0;
         rd_last_r  <= 1'b0;
         wr_done_r  <= 1'b0;
         rd_count_r <= '0;
         wr_count_r <= '0;
      end else begin
         state_r    <= state_s;
         ready_r    <= ready_d_s;
         rd_valid_r <= rd_valid_d_s;
         rd_data_r  <= rd_data_d_s;
         rd_word_r  <= rd_word_d_s;
         rd_last_r  <= rd_last_d_s;
         wr_done_r  <= wr_done_d_s;
         beat_r     <= (state_s == BURST) ? nxt_beat_s : '0;
         if (fire_s) begin
            line_r  <= bus.req_addr[ADDR_W-1:OFF];
            start_r <= bus.req_addr[OFF-1:2];
            write_r <= bus.req_write;
            wdata_r <= bus.req_wdata;
            cnt_r   <= LAT_W'(LATENCY - 1);
            if (bus.req_write) wr_count_r <= wr_count_r + CNT_W'(1);
            else               rd_count_r <= rd_count_r + CNT_W'(1);
         end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - LAT_W'(1);
         end
      end
   end

   // Writeback commit: the whole line lands at the edge ending the WDONE cycle.
   always_ff @(posedge clk) begin
      if (state_r == WDONE) begin
         for (int w = 0; w < WORDS; w++) begin
            mem_r[{line_r, WI'(w)}] <= wdata_r[w*DATA_W +: DATA_W] ^ init_word({line_r, WI'(w)});
         end
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_data   = rd_data_r;
   assign bus.rd_word   = rd_word_r;
   assign bus.rd_last   = rd_last_r;
   assign bus.wr_done   = wr_done_r;
   assign bus.rd_count  = rd_count_r;
   assign bus.wr_count  = wr_count_r;
endmodule

// File: tb/tb_line_fill_mem.sv
// Directed self-checking bench for line_fill_mem: a LATENCY=4 instance for the
// main scenarios and a LATENCY=1 instance for the short-latency build.
module tb_line_fill_mem;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_rd   = 0;
   int   exp_wr   = 0;

   always #5 clk = ~clk;

   line_fill_mem_if m0 ();
   line_fill_mem_if m1 ();

   line_fill_mem #(.LATENCY(4)) u0 (.clk(clk), .rst(rst), .bus(m0));
   line_fill_mem #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(m1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request to m0 in the first cycle it is ready; returns in cycle T+1.
   task automatic issue(input logic wr, input logic [11:0] addr, input logic [127:0] wd);
      int guard;
      guard = 0;
      while (m0.req_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_checks++;
      if (m0.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_ready_timeout: req_ready=%b, required 1", m0.req_ready);
      end
      m0.req_valid = 1'b1;
      m0.req_write = wr;
      m0.req_addr  = addr;
      m0.req_wdata = wd;
      tick();
      m0.req_valid = 1'b0;
      m0.req_write = ~wr;
      m0.req_addr  = 12'hFFF;
      m0.req_wdata = {128{1'b1}};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_checks++;
      if ({m0.req_ready, m0.rd_valid, m0.rd_last, m0.wr_done, m0.rd_word, m0.rd_data, m0.rd_count, m0.wr_count} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_m0: rdy=%b v=%b l=%b wd=%b w=%0d d=%h rc=%0d wc=%0d, required all 0",
                  m0.req_ready, m0.rd_valid, m0.rd_last, m0.wr_done, m0.rd_word, m0.rd_data, m0.rd_count, m0.wr_count);
      end
      n_checks++;
      if ({m1.req_ready, m1.rd_valid, m1.rd_last, m1.wr_done, m1.rd_count, m1.wr_count} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_m1: rdy=%b v=%b rc=%0d wc=%0d, required all 0", m1.req_ready, m1.rd_valid, m1.rd_count, m1.wr_count);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if ({m0.req_ready, m1.req_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready_idle: got %b%b, required 11", m0.req_ready, m1.req_ready);
      end
   endtask

   task automatic test_fill_aligned();
      issue(1'b0, 12'h040, 128'd0);
      exp_rd++;
      n_checks++;
      if (m0.rd_count !== 16'(exp_rd) || m0.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL aligned_accept: rd_count=%0d ready=%b, required %0d 0", m0.rd_count, m0.req_ready, exp_rd);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (m0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_early_beat[%0d]: rd_valid=%b, required 0", i, m0.rd_valid); end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (m0.rd_valid !== 1'b1 || m0.rd_word !== 2'(k) || m0.rd_data !== (32'hA000_0010 + 32'(k)) || m0.rd_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL aligned_beat[%0d]: v=%b w=%0d d=%h l=%b, required 1 %0d %h %b",
                     k, m0.rd_valid, m0.rd_word, m0.rd_data, m0.rd_last, k, 32'hA000_0010 + 32'(k), k == 3);
         end
         tick();
      end
      n_checks++;
      if (m0.req_ready !== 1'b1 || m0.rd_valid !== 1'b0 || m0.rd_data !== 32'd0) begin
         n_fail++;
         $display("FAIL aligned_done: ready=%b v=%b d=%h, required 1 0 0", m0.req_ready, m0.rd_valid, m0.rd_data);
      end
   endtask

   task automatic test_fill_wrap();
      logic [1:0] w;
      issue(1'b0, 12'h04C, 128'd0);
      exp_rd++;
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         w = 2'(3 + k);
         n_checks++;
         if (m0.rd_valid !== 1'b1 || m0.rd_word !== w || m0.rd_data !== (32'hA000_0010 | 32'(w)) || m0.rd_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL wrap_beat[%0d]: v=%b w=%0d d=%h l=%b, required 1 %0d %h %b",
                     k, m0.rd_valid, m0.rd_word, m0.rd_data, m0.rd_last, w, 32'hA000_0010 | 32'(w), k == 3);
         end
         tick();
      end
      n_checks++;
      if (m0.rd_count !== 16'(exp_rd)) begin n_fail++; $display("FAIL wrap_rd_count: got %0d, required %0d", m0.rd_count, exp_rd); end
   endtask

   task automatic test_writeback();
      logic [31:0] wb [4];
      wb = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
      issue(1'b1, 12'h7F5, {wb[3], wb[2], wb[1], wb[0]});
      exp_wr++;
      n_checks++;
      if (m0.wr_count !== 16'(exp_wr) || m0.rd_count !== 16'(exp_rd)) begin
         n_fail++;
         $display("FAIL wb_counts: wr=%0d rd=%0d, required %0d %0d", m0.wr_count, m0.rd_count, exp_wr, exp_rd);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (m0.wr_done !== 1'b0) begin n_fail++; $display("FAIL wb_early_done[%0d]: wr_done=%b, required 0", i, m0.wr_done); end
         tick();
      end
      n_checks++;
      if (m0.wr_done !== 1'b1 || m0.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wb_done_pulse: wr_done=%b ready=%b, required 1 0", m0.wr_done, m0.req_ready);
      end
      tick();
      n_checks++;
      if (m0.wr_done !== 1'b0 || m0.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_after_done: wr_done=%b ready=%b, required 0 1", m0.wr_done, m0.req_ready);
      end
      issue(1'b0, 12'h7F0, 128'd0);
      exp_rd++;
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (m0.rd_valid !== 1'b1 || m0.rd_word !== 2'(k) || m0.rd_data !== wb[k]) begin
            n_fail++;
            $display("FAIL raw_beat[%0d]: v=%b w=%0d d=%h, required 1 %0d %h", k, m0.rd_valid, m0.rd_word, m0.rd_data, k, wb[k]);
         end
         tick();
      end
   endtask

   task automatic test_busy();
      logic [1:0] w;
      issue(1'b0, 12'h100, 128'd0);
      exp_rd++;
      m0.req_valid = 1'b1;
      m0.req_write = 1'b0;
      m0.req_addr  = 12'h204;
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (m0.rd_data !== (32'hA000_0040 + 32'(k)) || m0.rd_count !== 16'(exp_rd) || m0.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_first_beat[%0d]: d=%h rc=%0d rdy=%b, required %h %0d 0",
                     k, m0.rd_data, m0.rd_count, m0.req_ready, 32'hA000_0040 + 32'(k), exp_rd);
         end
         tick();
      end
      n_checks++;
      if (m0.req_ready !== 1'b1 || m0.rd_count !== 16'(exp_rd)) begin
         n_fail++;
         $display("FAIL busy_held_ready: ready=%b rc=%0d, required 1 %0d", m0.req_ready, m0.rd_count, exp_rd);
      end
      tick();
      m0.req_valid = 1'b0;
      exp_rd++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (m0.rd_valid !== 1'b0 || m0.rd_count !== 16'(exp_rd)) begin
            n_fail++;
            $display("FAIL busy_second_wait[%0d]: v=%b rc=%0d, required 0 %0d", i, m0.rd_valid, m0.rd_count, exp_rd);
         end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         w = 2'(1 + k);
         n_checks++;
         if (m0.rd_valid !== 1'b1 || m0.rd_word !== w || m0.rd_data !== (32'hA000_0080 | 32'(w))) begin
            n_fail++;
            $display("FAIL busy_second_beat[%0d]: v=%b w=%0d d=%h, required 1 %0d %h",
                     k, m0.rd_valid, m0.rd_word, m0.rd_data, w, 32'hA000_0080 | 32'(w));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 12'h080, 128'd0);
      tick();
      tick();
      tick();
      tick();
      n_checks++;
      if (m0.rd_valid !== 1'b1 || m0.rd_word !== 2'd1) begin
         n_fail++;
         $display("FAIL rstmid_second_beat: v=%b w=%0d, required 1 1", m0.rd_valid, m0.rd_word);
      end
      rst = 1'b1;
      #1;
      exp_rd = 0;
      exp_wr = 0;
      n_checks++;
      if (m0.rd_valid !== 1'b0 || m0.rd_data !== 32'd0 || m0.rd_count !== 16'd0 || m0.wr_count !== 16'd0 || m0.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_abort: v=%b d=%h rc=%0d wc=%0d rdy=%b, required 0 0 0 0 0",
                  m0.rd_valid, m0.rd_data, m0.rd_count, m0.wr_count, m0.req_ready);
      end
      tick();
      rst = 1'b0;
      issue(1'b1, 12'h300, {4{32'h5555_5555}});
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (m0.wr_done !== 1'b0 || m0.wr_count !== 16'd0) begin
         n_fail++;
         $display("FAIL rstwr_abort: wr_done=%b wc=%0d, required 0 0", m0.wr_done, m0.wr_count);
      end
      tick();
      rst = 1'b0;
      issue(1'b0, 12'h300, 128'd0);
      exp_rd++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (m0.wr_done !== 1'b0) begin n_fail++; $display("FAIL rstwr_late_done[%0d]: wr_done=%b, required 0", i, m0.wr_done); end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (m0.rd_valid !== 1'b1 || m0.rd_data !== (32'hA000_00C0 + 32'(k))) begin
            n_fail++;
            $display("FAIL rstwr_orig_data[%0d]: v=%b d=%h, required 1 %h", k, m0.rd_valid, m0.rd_data, 32'hA000_00C0 + 32'(k));
         end
         tick();
      end
      n_checks++;
      if (m0.rd_count !== 16'(exp_rd) || m0.wr_count !== 16'(exp_wr)) begin
         n_fail++;
         $display("FAIL rstmid_counts: rc=%0d wc=%0d, required %0d %0d", m0.rd_count, m0.wr_count, exp_rd, exp_wr);
      end
   endtask

   task automatic test_latency1();
      int guard;
      guard = 0;
      while (m1.req_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      m1.req_valid = 1'b1;
      m1.req_write = 1'b0;
      m1.req_addr  = 12'h010;
      tick();
      m1.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (m1.rd_valid !== 1'b1 || m1.rd_word !== 2'(k) || m1.rd_data !== (32'hA000_0004 + 32'(k)) || m1.rd_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL lat1_beat[%0d]: v=%b w=%0d d=%h l=%b, required 1 %0d %h %b",
                     k, m1.rd_valid, m1.rd_word, m1.rd_data, m1.rd_last, k, 32'hA000_0004 + 32'(k), k == 3);
         end
         tick();
      end
      n_checks++;
      if (m1.req_ready !== 1'b1 || m1.rd_valid !== 1'b0 || m1.rd_count !== 16'd1) begin
         n_fail++;
         $display("FAIL lat1_read_done: ready=%b v=%b rc=%0d, required 1 0 1", m1.req_ready, m1.rd_valid, m1.rd_count);
      end
      m1.req_valid = 1'b1;
      m1.req_write = 1'b1;
      m1.req_addr  = 12'h020;
      m1.req_wdata = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      tick();
      m1.req_valid = 1'b0;
      n_checks++;
      if (m1.wr_done !== 1'b1 || m1.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL lat1_wr_done: wr_done=%b ready=%b, required 1 0", m1.wr_done, m1.req_ready);
      end
      tick();
      n_checks++;
      if (m1.wr_done !== 1'b0 || m1.req_ready !== 1'b1 || m1.wr_count !== 16'd1) begin
         n_fail++;
         $display("FAIL lat1_wr_after: wr_done=%b ready=%b wc=%0d, required 0 1 1", m1.wr_done, m1.req_ready, m1.wr_count);
      end
      m1.req_valid = 1'b1;
      m1.req_write = 1'b0;
      m1.req_addr  = 12'h028;
      tick();
      m1.req_valid = 1'b0;
      n_checks++;
      if (m1.rd_valid !== 1'b1 || m1.rd_word !== 2'd2 || m1.rd_data !== 32'h3333_0002) begin
         n_fail++;
         $display("FAIL lat1_raw_first: v=%b w=%0d d=%h, required 1 2 33330002", m1.rd_valid, m1.rd_word, m1.rd_data);
      end
      tick();
      n_checks++;
      if (m1.rd_word !== 2'd3 || m1.rd_data !== 32'h4444_0003) begin
         n_fail++;
         $display("FAIL lat1_raw_second: w=%0d d=%h, required 3 44440003", m1.rd_word, m1.rd_data);
      end
      tick();
      tick();
      tick();
   endtask

   initial begin
      m0.req_valid = 1'b0;
      m0.req_write = 1'b0;
      m0.req_addr  = 12'h000;
      m0.req_wdata = 128'd0;
      m1.req_valid = 1'b0;
      m1.req_write = 1'b0;
      m1.req_addr  = 12'h000;
      m1.req_wdata = 128'd0;
      test_reset();
      test_fill_aligned();
      test_fill_wrap();
      test_writeback();
      test_busy();
      test_reset_mid();
      test_latency1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
